// File: rtl/fifo_sum_pkg.sv
// rtl/fifo_sum_pkg.sv - shared types and helpers for the three-row column-sum controller
package fifo_sum_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    FILL1 = 2'd0,
    FILL2 = 2'd1,
    SUM   = 2'd2
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_sum_outq.sv
// rtl/fifo_sum_outq.sv - one-entry pending register feeding the UART transmitter
module fifo_sum_outq
  import fifo_sum_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sum_vld_i,
  input  logic [BYTE_W-1:0] sum_i,
  input  logic              sum_last_i,
  input  logic              busy_i,
  output logic              po_flag_o,
  output logic [BYTE_W-1:0] po_sum_o,
  output logic              ovf_o,
  output logic              frame_done_o
);

  logic              pend_vld_q, pend_vld_d;
  logic [BYTE_W-1:0] pend_q, pend_d;
  logic              pend_last_q, pend_last_d;
  logic              guard_q;
  logic              ovf_q, ovf_d;
  logic              fd_q, fd_d;
  logic              issue;
  logic              drop;

  // The transmitter raises busy one cycle late, so the guard suppresses the cycle after an issue.
  assign issue        = pend_vld_q && !busy_i && !guard_q;
  assign po_flag_o    = issue;
  assign po_sum_o     = pend_q;
  assign ovf_o        = ovf_q;
  assign frame_done_o = fd_q;

  // Pending-slot update: issuing frees the slot, a new sum takes it only if it is free by then.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    drop        = 1'b0;
    if (issue) begin
      pend_vld_d = 1'b0;
    end
    if (sum_vld_i) begin
      if (!pend_vld_q || issue) begin
        pend_vld_d  = 1'b1;
        pend_d      = sum_i;
        pend_last_d = sum_last_i;
      end else begin
        drop = 1'b1;
      end
    end
    ovf_d = ovf_q || drop;
    // A frame ends when its final sum leaves, whether it went out or was thrown away.
    fd_d  = (issue && pend_last_q) || (drop && sum_last_i);
  end

  // Output-stage state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      pend_last_q <= 1'b0;
      guard_q     <= 1'b0;
      ovf_q       <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      guard_q     <= issue;
      ovf_q       <= ovf_d;
      fd_q        <= fd_d;
    end
  end

endmodule

// File: rtl/fifo_sum_ctrl.sv
// rtl/fifo_sum_ctrl.sv - sequences two line FIFOs to sum three adjacent rows per column
module fifo_sum_ctrl
  import fifo_sum_pkg::*;
#(
  parameter int COL_NUM = 50,
  parameter int ROW_NUM = 50
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              pi_flag,
  input  logic [BYTE_W-1:0] pi_data,
  output logic              wr_en1,
  output logic [BYTE_W-1:0] wr_data1,
  output logic              wr_en2,
  output logic [BYTE_W-1:0] wr_data2,
  output logic              rd_en,
  input  logic [BYTE_W-1:0] q1,
  input  logic [BYTE_W-1:0] q2,
  input  logic              busy_flag,
  output logic              po_flag,
  output logic [BYTE_W-1:0] po_sum,
  output logic              ovf,
  output logic              frame_done
);

  localparam int CW = cnt_w(COL_NUM);
  localparam int RW = cnt_w(ROW_NUM);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              col_wrap;

  logic              wr1_q, wr2_q;
  logic [BYTE_W-1:0] data1_q;
  logic              rd_q, wb1_q, last1_q;
  logic              v2_q, wb2_q, last2_q;
  logic [BYTE_W-1:0] byte2_q;
  logic              sum_vld_q, sum_last_q;
  logic [BYTE_W-1:0] sum_q;

  // In the write-back cycle the FIFOs are fed straight from fifo_2's output and the held byte.
  assign wr_en1   = wr1_q || wb2_q;
  assign wr_en2   = wr2_q || wb2_q;
  assign wr_data1 = wb2_q ? q2 : data1_q;
  assign wr_data2 = wb2_q ? byte2_q : data1_q;
  assign rd_en    = rd_q;

  // Column/row position and phase of the frame, advanced by each received byte.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    col_wrap = (col_q == COL_LAST);
    if (pi_flag) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        case (state_q)
          FILL1:   state_d = FILL2;
          FILL2:   state_d = SUM;
          SUM:     if (row_q == ROW_LAST) state_d = FILL1;
          default: state_d = FILL1;
        endcase
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Phase and position registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL1;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Three-stage byte pipeline: issue read, write back / add, present sum.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr1_q      <= 1'b0;
      wr2_q      <= 1'b0;
      data1_q    <= '0;
      rd_q       <= 1'b0;
      wb1_q      <= 1'b0;
      last1_q    <= 1'b0;
      v2_q       <= 1'b0;
      wb2_q      <= 1'b0;
      last2_q    <= 1'b0;
      byte2_q    <= '0;
      sum_vld_q  <= 1'b0;
      sum_last_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      wr1_q   <= pi_flag && (state_q == FILL1);
      wr2_q   <= pi_flag && (state_q == FILL2);
      rd_q    <= pi_flag && (state_q == SUM);
      if (pi_flag) begin
        data1_q <= pi_data;
        // The last row only drains the FIFOs; nothing of it is needed later.
        wb1_q   <= (row_q != ROW_LAST);
        last1_q <= (row_q == ROW_LAST) && col_wrap;
      end
      v2_q       <= rd_q;
      wb2_q      <= rd_q && wb1_q;
      last2_q    <= rd_q && last1_q;
      byte2_q    <= data1_q;
      sum_vld_q  <= v2_q;
      sum_last_q <= v2_q && last2_q;
      sum_q      <= q1 + q2 + byte2_q;
    end
  end

  fifo_sum_outq u_outq (
    .clk_i        (sys_clk),
    .rst_ni       (rst_n),
    .sum_vld_i    (sum_vld_q),
    .sum_i        (sum_q),
    .sum_last_i   (sum_last_q),
    .busy_i       (busy_flag),
    .po_flag_o    (po_flag),
    .po_sum_o     (po_sum),
    .ovf_o        (ovf),
    .frame_done_o (frame_done)
  );

endmodule

// File: tb/tb_fifo_sum_ctrl.sv
// tb/tb_fifo_sum_ctrl.sv - scoreboard bench for the three-row column-sum controller
module tb_fifo_sum_ctrl;

  localparam int COL = 3;
  localparam int ROW = 4;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pi_flag = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic       busy_flag = 1'b0;
  logic [7:0] q1 = 8'h00;
  logic [7:0] q2 = 8'h00;
  logic       wr_en1, wr_en2, rd_en, po_flag, ovf, frame_done;
  logic [7:0] wr_data1, wr_data2, po_sum;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int last_po_cyc = -1;

  typedef struct packed {
    logic [7:0] val;
    logic       drop;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] f1[$];
  logic [7:0] f2[$];
  logic [7:0] m[ROW][COL];
  int         mr = 0;
  int         mc = 0;

  fifo_sum_ctrl #(.COL_NUM(COL), .ROW_NUM(ROW)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .pi_flag    (pi_flag),
    .pi_data    (pi_data),
    .wr_en1     (wr_en1),
    .wr_data1   (wr_data1),
    .wr_en2     (wr_en2),
    .wr_data2   (wr_data2),
    .rd_en      (rd_en),
    .q1         (q1),
    .q2         (q2),
    .busy_flag  (busy_flag),
    .po_flag    (po_flag),
    .po_sum     (po_sum),
    .ovf        (ovf),
    .frame_done (frame_done)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic int live_cnt();
    int c = 0;
    foreach (exp_q[i]) if (!exp_q[i].drop) c++;
    return c;
  endfunction

  // Behavioural line FIFOs, depth COL, normal mode, cleared by the same reset.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      f1.delete();
      f2.delete();
      q1 <= 8'h00;
      q2 <= 8'h00;
    end else begin
      if (rd_en) begin
        chk("rd_fifo1_nonempty", f1.size() > 0, 1);
        chk("rd_fifo2_nonempty", f2.size() > 0, 1);
        if (f1.size() > 0) q1 <= f1.pop_front();
        if (f2.size() > 0) q2 <= f2.pop_front();
      end
      if (wr_en1) begin
        chk("wr_fifo1_notfull", f1.size() < COL, 1);
        f1.push_back(wr_data1);
      end
      if (wr_en2) begin
        chk("wr_fifo2_notfull", f2.size() < COL, 1);
        f2.push_back(wr_data2);
      end
    end
  end

  // Monitor: every transmitted sum is matched against the oldest non-dropped expectation.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (po_flag) begin
        chk("po_while_busy", busy_flag, 0);
        while (exp_q.size() > 0 && exp_q[0].drop) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL po_unexpected: got sum %0d with nothing expected", po_sum);
        end else begin
          mon_e = exp_q.pop_front();
          chk("po_sum", po_sum, mon_e.val);
        end
        last_po_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("frame_done_after_last_sum", live_cnt(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  // Drive one byte and record, from the matrix model, the sum it completes.
  task automatic send(input logic [7:0] b, input int gap, input logic drop);
    exp_t e;
    pi_flag = 1'b1;
    pi_data = b;
    m[mr][mc] = b;
    if (mr >= 2) begin
      e.val  = 8'(m[mr-2][mc] + m[mr-1][mc] + b);
      e.drop = drop;
      exp_q.push_back(e);
    end
    if (mc == COL - 1) begin
      mc = 0;
      mr = (mr == ROW - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
    tick();
    pi_flag = 1'b0;
    repeat (gap - 1) tick();
  endtask

  // mode 0: start, start+1, ...; mode 1: all 0xFF; mode 2: random bytes and spacing
  task automatic send_frame(input int mode, input int start);
    logic [7:0] b;
    int gap;
    for (int i = 0; i < ROW * COL; i++) begin
      b = (mode == 0) ? 8'(start + i) : (mode == 1) ? 8'hFF : 8'($urandom);
      gap = (mode == 2) ? int'($urandom_range(12, 4)) : 10;
      send(b, gap, 1'b0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (live_cnt() != 0 && n < 400) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({name, "_all_sums_seen"}, live_cnt(), 0);
    chk({name, "_fifo1_empty"}, f1.size(), 0);
    chk({name, "_fifo2_empty"}, f2.size(), 0);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    repeat (3) tick();
    mr = 0;
    mc = 0;
    exp_q.delete();
    chk({name, "_ctrl_outs"}, {wr_en1, wr_en2, rd_en, po_flag, ovf, frame_done}, 0);
    chk({name, "_data_outs"}, {wr_data1, wr_data2, po_sum}, 0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int fd0;
    int rel_cyc;
    do_reset("reset");

    // counting frame, busy idle
    fd0 = fd_cnt;
    send_frame(0, 1);
    wait_drain("s1");
    chk("s1_frame_done_count", fd_cnt - fd0, 1);
    chk("s1_ovf", ovf, 0);

    // saturating bytes wrap the sum modulo 256
    fd0 = fd_cnt;
    send_frame(1, 0);
    wait_drain("s2");
    chk("s2_frame_done_count", fd_cnt - fd0, 1);

    // one sum held back by a long busy period
    fd0 = fd_cnt;
    for (int i = 0; i < ROW * COL; i++) begin
      if (i == 6) begin
        busy_flag = 1'b1;
        send(8'(i + 1), 200, 1'b0);
        busy_flag = 1'b0;
        rel_cyc = cyc;
        repeat (4) tick();
        chk("s3_issue_after_release", (last_po_cyc >= rel_cyc) && (last_po_cyc <= rel_cyc + 2), 1);
      end else begin
        send(8'(i + 1), 10, 1'b0);
      end
    end
    wait_drain("s3");
    chk("s3_frame_done_count", fd_cnt - fd0, 1);
    chk("s3_ovf", ovf, 0);

    // busy across two sums: the second is lost and ovf latches
    fd0 = fd_cnt;
    for (int i = 0; i < ROW * COL; i++) begin
      if (i == 7) begin
        busy_flag = 1'b1;
        send(8'(i + 1), 10, 1'b0);
      end else if (i == 8) begin
        send(8'(i + 1), 6, 1'b1);
        busy_flag = 1'b0;
      end else begin
        send(8'(i + 1), 10, 1'b0);
      end
    end
    wait_drain("s4");
    chk("s4_frame_done_count", fd_cnt - fd0, 1);
    chk("s4_ovf_set", ovf, 1);
    repeat (20) tick();
    chk("s4_ovf_sticky", ovf, 1);

    // reset in the middle of the second row, then a clean frame
    for (int i = 0; i < 5; i++) send(8'(i + 1), 10, 1'b0);
    do_reset("s5_reset");
    fd0 = fd_cnt;
    send_frame(0, 1);
    wait_drain("s5");
    chk("s5_frame_done_count", fd_cnt - fd0, 1);
    chk("s5_ovf", ovf, 0);

    // two frames back to back
    fd0 = fd_cnt;
    send_frame(0, 1);
    send_frame(0, 13);
    wait_drain("s6");
    chk("s6_frame_done_count", fd_cnt - fd0, 2);

    // random bytes with random legal spacing
    fd0 = fd_cnt;
    for (int k = 0; k < 3; k++) send_frame(2, 0);
    wait_drain("s7");
    chk("s7_frame_done_count", fd_cnt - fd0, 3);
    chk("s7_ovf", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge sys_clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
